// File: rtl/adder_pkg.sv
// Shared definitions for the adder datapath and its result FIFO.
package adder_pkg;

    // Default adder width. A result word is {cout, sum}, which is one bit wider than the sum.
    localparam int ADDER_WIDTH = 4;

    typedef struct packed {
        logic                   cout;
        logic [ADDER_WIDTH-1:0] sum;
    } result_t;

    // Number of address bits needed to index a storage array with the given depth.
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Width of a {cout, sum} result word for the given adder width.
    function automatic int result_w(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the result FIFO: one synchronous write port and a
// combinational read port, so the head entry can be shown ahead of the pop.
module fifo_mem #(
    parameter int DW    = 5,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // Write the incoming entry; the contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/adder_result_fifo.sv
// Result FIFO behind the adder. The adder cannot be stalled, so every flagged
// result is either stored or counted as dropped. The consumer reads the head
// entry over a valid/ready handshake.
module adder_result_fifo
    import adder_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_sum,
    input  logic                  in_cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_sum,
    output logic                  out_cout,
    output logic                  full,
    output logic                  empty,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]      drop_cnt,
    output logic                  carry_seen
);

    localparam int AW = addr_w(DEPTH);
    localparam int RW = result_w(WIDTH);

    typedef struct packed {
        logic             cout;
        logic [WIDTH-1:0] sum;
    } w_result_t;

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_carry_seen;

    logic      w_full;
    logic      w_empty;
    logic      w_pop;
    logic      w_push;
    logic      w_drop;
    logic      w_we;
    w_result_t w_wr_data;
    w_result_t w_rd_data;

    // The counter stops at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign w_pop  = !w_empty && out_ready;
    assign w_push = in_valid && (!w_full || w_pop);
    assign w_drop = in_valid && w_full && !w_pop;
    assign w_we   = w_push && !clr;

    assign w_wr_data.cout = in_cout;
    assign w_wr_data.sum  = in_sum;

    fifo_mem #(
        .DW    (RW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (w_wr_data),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rd_data)
    );

    // Advance the pointers on push/pop. A clear flushes everything and wins over both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Count the results that were lost because the FIFO was full, and the sticky carry flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt   <= '0;
            r_carry_seen <= 1'b0;
        end else if (clr) begin
            r_drop_cnt   <= '0;
            r_carry_seen <= 1'b0;
        end else begin
            if (w_drop)            r_drop_cnt   <= sat_inc(r_drop_cnt);
            if (w_push && in_cout) r_carry_seen <= 1'b1;
        end
    end

    assign out_valid  = !w_empty;
    assign empty      = w_empty;
    assign full       = w_full;
    assign level      = r_wr_ptr - r_rd_ptr;
    assign drop_cnt   = r_drop_cnt;
    assign carry_seen = r_carry_seen;

    // The head word is masked so that stale storage never appears while the FIFO is empty.
    assign out_sum  = w_empty ? '0   : w_rd_data.sum;
    assign out_cout = w_empty ? 1'b0 : w_rd_data.cout;

endmodule
